cop0_unit: RTL
==============

Name: cop0_unit

Overview:
Coprocessor-0 responder for the single-cycle MIPS core: it services the `iscop0` and `issyscall` decode outputs of the control unit.
- Holds Status (12), Cause (13) and EPC (14).
- Executes mfc0, mtc0 and eret.
- Latches external interrupt requests and takes syscall or interrupt exceptions at instruction boundaries by redirecting the PC to a fixed handler address.
- Sits beside the PC-select mux and the register-file writeback path.

Parameters:
HANDLER_ADDR, 32'h0000_0800, exception vector driven on redirect_pc when an exception is taken
N_IRQ, 3, number of external interrupt lines (max 6; maps to Cause/Status bits [8+N_IRQ-1:8])

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  current instruction valid and committing this cycle
iscop0  in  1  control-unit flag: op = 010000
issyscall  in  1  control-unit flag: R-type func = 001100
cop0_rs  in  5  instr[25:21]: 00000 mfc0, 00100 mtc0, 10000 eret (with func = 011000)
cop0_rd  in  5  instr[15:11]: CP0 register number
func  in  6  instr[5:0]
pc  in  32  address of current instruction
rt_data  in  32  rt register value (mtc0 source)
irq  in  N_IRQ  external interrupt requests, level, synchronous to clk
cp0_rdata  out  32  mfc0 read data, combinational
redirect  out  1  override next PC this cycle, combinational
redirect_pc  out  32  next PC when redirect = 1
kill  out  1  suppress regwrite/memwrite of current instruction (interrupt only)
in_handler  out  1  state == HANDLER
epc  out  32  current EPC register

Behaviour:
- Reset (rst = 1 at posedge) sets:
  - Status = 32'h0000_0700 (IE = bit0 = 0; IM = [10:8] = all ones).
  - Cause = 0 (IP = [10:8], ExcCode = [6:2]).
  - EPC = 0; state = RUN.
  - Every registered-state-derived output is 0 after reset; cp0_rdata follows its decode.
  - Reset wins over every other event in the same cycle.
- IP latching, every cycle regardless of en:
  - IP_next = (IP | irq) & ~clr, where clr comes from an mtc0 write or exception entry.
  - If irq and clr hit the same bit in the same cycle, the set wins (bit stays 1).
- Instruction decode, all qualified by en:
  - mfc0: iscop0 & cop0_rs = 00000.
  - mtc0: iscop0 & cop0_rs = 00100.
  - eret: iscop0 & cop0_rs = 10000 & func = 011000.
- mfc0: cp0_rdata = Status, Cause or EPC for rd = 12, 13 or 14; any other rd returns 0. The read is combinational with zero latency and shows pre-edge values.
- mtc0 writes at posedge:
  - rd = 12: IE and IM only; other bits read 0.
  - rd = 13: IP bits are clear-only (IP &= rt_data[10:8]); ExcCode is read-only.
  - rd = 14: full 32-bit EPC.
  - Any other rd: ignored.
- State machine (RUN, HANDLER), evaluated with en = 1 in priority order:
  1. RUN & syscall:
     - redirect = 1, redirect_pc = HANDLER_ADDR, kill = 0.
     - At posedge: EPC = pc + 4, ExcCode = 8, IE = 0, state -> HANDLER.
  2. RUN & IE & |(IP & IM) & not (syscall or iscop0):
     - redirect = 1, redirect_pc = HANDLER_ADDR, kill = 1.
     - At posedge: EPC = pc, ExcCode = 0, IE = 0, state -> HANDLER.
     - The lowest-index pending enabled line wins; its IP bit is cleared.
  3. eret, from any state: redirect = 1, redirect_pc = EPC; at posedge IE = 1, state -> RUN.
  4. HANDLER & syscall: ignored. No redirect, no state change; the instruction completes as a nop.
- Interrupts are never taken in HANDLER (IE = 0), while en = 0, or on a cop0/syscall instruction.
- pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- mtc0 to Status setting IE = 1 while pending: the interrupt is taken no earlier than the next enabled instruction.
- en = 0: no register or state change except IP latching; redirect = 0, kill = 0.

Decomposition:
- Shared package `cp0_defs` holds:
  - CP0 register numbers 12/13/14.
  - rs codes MFC0/MTC0/ERET, func ERET = 6'b011000.
  - ExcCodes INT = 0, SYS = 8.
  - Status/Cause bit positions and the state encoding RUN/HANDLER.
- One sub-module, `irq_pri_enc`: N_IRQ-wide mask-and-priority encoder producing `any` and a one-hot `sel` (lowest index first).

Test Plan:
- Reset, then mfc0 rd = 12/13/14 -> cp0_rdata = 32'h0000_0700, 0, 0; redirect = 0.
- syscall at pc = 32'h0000_0040, en = 1:
  - Same cycle: redirect = 1, redirect_pc = 32'h0000_0800, kill = 0.
  - Next cycle: EPC = 32'h0000_0044, Cause[6:2] = 8, in_handler = 1.
- irq = 3'b110 with IE = 0, then mtc0 Status = 32'h0000_0701, then an add at pc = 32'h0000_0100 ->
  - kill = 1, redirect = 1.
  - EPC = 32'h0000_0100; IP = 3'b100 after the edge (irq[1] taken, cleared).
  - irq[2] is still pending.
- In HANDLER: eret -> redirect_pc = EPC, in_handler = 0, Status[0] = 1. On the next en cycle the pending irq[2] is taken at once.
- Simultaneous events:
  - syscall plus a pending enabled irq -> syscall taken (ExcCode = 8, kill = 0).
  - mtc0 Cause = 0 in the same cycle irq[0] rises -> IP[0] = 1.
- Edge cases:
  - syscall at pc = 32'hFFFF_FFFC -> EPC = 0.
  - rst asserted while in HANDLER with IP set -> all registers at reset values, in_handler = 0 the next cycle.

Source files
------------

// File: rtl/cop0_unit_pkg.sv
// Shared CP0 definitions: register numbers, instruction field codes,
// exception codes, register bit positions and controller state encoding.
package cp0_defs;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] RS_MFC0 = 5'b00000;
  localparam logic [4:0] RS_MTC0 = 5'b00100;
  localparam logic [4:0] RS_ERET = 5'b10000;
  localparam logic [5:0] FUNC_ERET = 6'b011000;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam int STATUS_IE_BIT = 0;
  localparam int IRQ_LSB       = 8;
  localparam int EXC_LSB       = 2;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  typedef struct packed {
    logic mtc0;
    logic eret;
    logic syscall;
  } cop0_op_t;

  // Only committing instructions (en = 1) produce an operation.
  function automatic cop0_op_t decode_op(input logic       en,
                                         input logic       iscop0,
                                         input logic       issyscall,
                                         input logic [4:0] rs,
                                         input logic [5:0] func);
    cop0_op_t op;
    op.mtc0    = en & iscop0 & (rs == RS_MTC0);
    op.eret    = en & iscop0 & (rs == RS_ERET) & (func == FUNC_ERET);
    op.syscall = en & issyscall;
    return op;
  endfunction

endpackage

// File: rtl/cop0_unit_if.sv
// Core-side connection of the CP0 responder: decoded instruction fields in,
// read data and PC override out.
interface cop0_unit_if #(parameter int N_IRQ = 3);
  logic              en;
  logic              iscop0;
  logic              issyscall;
  logic [4:0]        cop0_rs;
  logic [4:0]        cop0_rd;
  logic [5:0]        func;
  logic [31:0]       pc;
  logic [31:0]       rt_data;
  logic [N_IRQ-1:0]  irq;
  logic [31:0]       cp0_rdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              kill;
  logic              in_handler;
  logic [31:0]       epc;

  modport master (
    output en, iscop0, issyscall, cop0_rs, cop0_rd, func, pc, rt_data, irq,
    input  cp0_rdata, redirect, redirect_pc, kill, in_handler, epc
  );

  modport slave (
    input  en, iscop0, issyscall, cop0_rs, cop0_rd, func, pc, rt_data, irq,
    output cp0_rdata, redirect, redirect_pc, kill, in_handler, epc
  );
endinterface

// File: rtl/cop0_unit_irq_pri_enc.sv
// Masked fixed-priority encoder for pending interrupt lines; the lowest
// index wins and is reported one-hot on sel.
module irq_pri_enc #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         any,
  output logic [N-1:0] sel
);

  logic [N-1:0] pend;

  assign pend = req & mask;
  assign any  = |pend;

  for (genvar gi = 0; gi < N; gi++) begin : g_sel
    if (gi == 0) begin : g_first
      assign sel[gi] = pend[gi];
    end else begin : g_rest
      assign sel[gi] = pend[gi] & ~(|pend[gi-1:0]);
    end
  end

endmodule

// File: rtl/cop0_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC, mfc0/mtc0/eret, and syscall or
// interrupt entry at instruction boundaries via a PC redirect.
module cop0_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800,
  parameter int          N_IRQ        = 3
) (
  input  logic       clk,
  input  logic       rst,
  cop0_unit_if.slave bus
);

  logic              status_ie_reg, status_ie_next;
  logic [N_IRQ-1:0]  status_im_reg, status_im_next;
  logic [N_IRQ-1:0]  cause_ip_reg,  cause_ip_next;
  logic [4:0]        cause_exc_reg, cause_exc_next;
  logic [31:0]       epc_reg,       epc_next;
  logic [0:0]        state_reg,     state_next;

  logic [N_IRQ-1:0]  ip_clr;
  logic              irq_any;
  logic [N_IRQ-1:0]  irq_sel;
  cop0_op_t          op;
  logic              take_sys;
  logic              take_int;
  logic              do_eret;
  logic [31:0]       status_word;
  logic [31:0]       cause_word;

  assign op = decode_op(bus.en, bus.iscop0, bus.issyscall, bus.cop0_rs, bus.func);

  irq_pri_enc #(.N(N_IRQ)) u_pri_enc (
    .req  (cause_ip_reg),
    .mask (status_im_reg),
    .any  (irq_any),
    .sel  (irq_sel)
  );

  // Interrupts only break in on ordinary instructions so a cop0 or syscall
  // instruction never loses its own side effects.
  assign take_sys = op.syscall & (state_reg == ST_RUN);
  assign take_int = bus.en & (state_reg == ST_RUN) & status_ie_reg & irq_any
                    & ~bus.issyscall & ~bus.iscop0;
  assign do_eret  = op.eret;

  always_comb begin
    status_ie_next = status_ie_reg;
    status_im_next = status_im_reg;
    cause_exc_next = cause_exc_reg;
    epc_next       = epc_reg;
    state_next     = state_reg;
    ip_clr         = '0;

    if (op.mtc0) begin
      case (bus.cop0_rd)
        CP0_STATUS: begin
          status_ie_next = bus.rt_data[STATUS_IE_BIT];
          status_im_next = bus.rt_data[IRQ_LSB +: N_IRQ];
        end
        CP0_CAUSE: ip_clr   = ~bus.rt_data[IRQ_LSB +: N_IRQ];
        CP0_EPC:   epc_next = bus.rt_data;
        default: ;
      endcase
    end

    if (take_sys) begin
      epc_next       = bus.pc + 32'd4;
      cause_exc_next = EXC_SYS;
      status_ie_next = 1'b0;
      state_next     = ST_HANDLER;
    end else if (take_int) begin
      epc_next       = bus.pc;
      cause_exc_next = EXC_INT;
      status_ie_next = 1'b0;
      state_next     = ST_HANDLER;
      ip_clr         = irq_sel;
    end else if (do_eret) begin
      status_ie_next = 1'b1;
      state_next     = ST_RUN;
    end

    // A line still asserted keeps its pending bit even when cleared this cycle.
    cause_ip_next = (cause_ip_reg & ~ip_clr) | bus.irq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_ie_reg <= 1'b0;
      status_im_reg <= '1;
      cause_ip_reg  <= '0;
      cause_exc_reg <= EXC_INT;
      epc_reg       <= '0;
      state_reg     <= ST_RUN;
    end else begin
      status_ie_reg <= status_ie_next;
      status_im_reg <= status_im_next;
      cause_ip_reg  <= cause_ip_next;
      cause_exc_reg <= cause_exc_next;
      epc_reg       <= epc_next;
      state_reg     <= state_next;
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[STATUS_IE_BIT] = status_ie_reg;
    status_word[IRQ_LSB +: N_IRQ] = status_im_reg;
    cause_word                 = '0;
    cause_word[IRQ_LSB +: N_IRQ]  = cause_ip_reg;
    cause_word[EXC_LSB +: 5]   = cause_exc_reg;
  end

  always_comb begin
    case (bus.cop0_rd)
      CP0_STATUS: bus.cp0_rdata = status_word;
      CP0_CAUSE:  bus.cp0_rdata = cause_word;
      CP0_EPC:    bus.cp0_rdata = epc_reg;
      default:    bus.cp0_rdata = 32'h0;
    endcase
  end

  assign bus.redirect    = take_sys | take_int | do_eret;
  assign bus.redirect_pc = (take_sys | take_int) ? HANDLER_ADDR : epc_reg;
  assign bus.kill        = take_int;
  assign bus.in_handler  = (state_reg == ST_HANDLER);
  assign bus.epc         = epc_reg;

endmodule
